// File: rtl/bu2_nwc_pipe.sv
// Pipelined radix-2 NTT butterfly with a per-beat modulus, supporting Cooley-Tukey (forward)
// and Gentleman-Sande (inverse, optional halving) beats behind a valid/ready handshake.
module bu2_nwc_pipe #(
  parameter int unsigned DW      = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_mode,
  input  logic          in_halve,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] twiddle,
  input  logic [DW-1:0] modulus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] BU_a,
  output logic [DW-1:0] BU_b,
  output logic [DW-1:0] twiddle_BU_out,
  output logic [DW-1:0] modulus_BU_out,
  output logic          busy
);

  localparam int unsigned PW = 2 * DW;

  // x/2 mod q for odd q: add q first when x is odd so the shift is exact.
  function automatic logic [DW-1:0] mod_halve(input logic [DW:0] x, input logic [DW-1:0] q);
    logic [DW:0] t;
    t = x[0] ? x + {1'b0, q} : x;
    return t[DW:1];
  endfunction

  logic             stall;
  logic             accept;
  logic             mode_q;
  logic [MUL_LAT:0] v_all;

  logic             out_valid_q;
  logic [DW-1:0]    bu_a_q, bu_b_q, tw_out_q, mod_out_q;

  assign stall    = out_valid_q && !out_ready;
  assign busy     = (|v_all) || out_valid_q;
  // A beat of the other mode waits until the pipeline is empty.
  assign in_ready = !stall && !(in_valid && (in_mode != mode_q) && busy);
  assign accept   = in_valid && in_ready;

  // Input stage: GS add/sub and optional halving ahead of the multiplier.
  logic [DW:0]   sum_w, sum_r, dif_r;
  logic [DW-1:0] sum_h, dif_h, x_in, ma_in;

  always_comb begin
    sum_w = {1'b0, in1} + {1'b0, in2};
    sum_r = (sum_w >= {1'b0, modulus}) ? sum_w - {1'b0, modulus} : sum_w;
    dif_r = (in1 >= in2) ? {1'b0, in1} - {1'b0, in2}
                         : {1'b0, in1} + {1'b0, modulus} - {1'b0, in2};
    sum_h = in_halve ? mod_halve(sum_r, modulus) : sum_r[DW-1:0];
    dif_h = in_halve ? mod_halve(dif_r, modulus) : dif_r[DW-1:0];
    x_in  = in_mode ? sum_h : in1;
    ma_in = in_mode ? dif_h : in2;
  end

  logic          v0_q;
  logic [DW-1:0] x0_q, ma0_q, w0_q, q0_q;
  logic [PW-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      x0_q   <= '0;
      ma0_q  <= '0;
      w0_q   <= '0;
      q0_q   <= '0;
      mode_q <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= in_mode;
      end
      if (!stall) begin
        v0_q <= accept;
        if (accept) begin
          x0_q  <= x_in;
          ma0_q <= ma_in;
          w0_q  <= twiddle;
          q0_q  <= modulus;
        end
      end
    end
  end

  assign v_all[0] = v0_q;
  assign prod     = {{DW{1'b0}}, ma0_q} * {{DW{1'b0}}, w0_q};

  // Multiplier stages: full product registered first, exact reduction into the last stage.
  for (genvar g = 0; g < MUL_LAT; g++) begin : g_mul
    logic          v_q, v_src;
    logic [DW-1:0] x_q, w_q, m_q, x_src, w_src, m_src;
    logic [PW-1:0] p_q, p_src, p_d;

    if (g == 0) begin : g_first
      assign v_src = v0_q;
      assign x_src = x0_q;
      assign w_src = w0_q;
      assign m_src = q0_q;
      assign p_src = prod;
    end else begin : g_next
      assign v_src = g_mul[g-1].v_q;
      assign x_src = g_mul[g-1].x_q;
      assign w_src = g_mul[g-1].w_q;
      assign m_src = g_mul[g-1].m_q;
      assign p_src = g_mul[g-1].p_q;
    end

    if (g == MUL_LAT - 1) begin : g_reduce
      assign p_d = p_src % {{DW{1'b0}}, m_src};
    end else begin : g_pass
      assign p_d = p_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        x_q <= '0;
        w_q <= '0;
        m_q <= '0;
        p_q <= '0;
      end else if (!stall) begin
        v_q <= v_src;
        if (v_src) begin
          x_q <= x_src;
          w_q <= w_src;
          m_q <= m_src;
          p_q <= p_d;
        end
      end
    end

    assign v_all[g+1] = v_q;
  end

  // Output stage: CT add/sub, GS pass-through.
  logic          lv;
  logic [DW-1:0] lx, lw, lm, lr, ct_b, a_d, b_d;
  logic [PW-1:0] lp;
  logic [DW:0]   ct_s, ct_a;
  logic          unused_hi;

  assign lv = g_mul[MUL_LAT-1].v_q;
  assign lx = g_mul[MUL_LAT-1].x_q;
  assign lw = g_mul[MUL_LAT-1].w_q;
  assign lm = g_mul[MUL_LAT-1].m_q;
  assign lp = g_mul[MUL_LAT-1].p_q;
  assign lr = lp[DW-1:0];
  assign unused_hi = ^{lp[PW-1:DW], ct_a[DW]};

  always_comb begin
    ct_s = {1'b0, lx} + {1'b0, lr};
    ct_a = (ct_s >= {1'b0, lm}) ? ct_s - {1'b0, lm} : ct_s;
    ct_b = (lx >= lr) ? lx - lr : lx + lm - lr;
    a_d  = mode_q ? lx : ct_a[DW-1:0];
    b_d  = mode_q ? lr : ct_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bu_a_q      <= '0;
      bu_b_q      <= '0;
      tw_out_q    <= '0;
      mod_out_q   <= '0;
    end else if (!stall) begin
      out_valid_q <= lv;
      if (lv) begin
        bu_a_q    <= a_d;
        bu_b_q    <= b_d;
        tw_out_q  <= lw;
        mod_out_q <= lm;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign BU_a           = bu_a_q;
  assign BU_b           = bu_b_q;
  assign twiddle_BU_out = tw_out_q;
  assign modulus_BU_out = mod_out_q;

endmodule

// File: doc/bu2_nwc_pipe.md
BU2_NWC_PIPE -- requirements
Module: bu2_nwc_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: data, twiddle and modulus width.
REQ-002 SHALL have parameter MUL_LAT, default 2, legal 1..4: register stages in the modular multiplier.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  input beat present.
REQ-006 SHALL have port in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_mode  in  1  0 = Cooley-Tukey (CT, forward), 1 = Gentleman-Sande (GS, inverse).
REQ-008 SHALL have port in_halve  in  1  GS only: scale both results by 2^-1 mod q.
REQ-009 SHALL have ports in1, in2, twiddle, modulus  in  DW each: operands, twiddle w, odd modulus q.
REQ-010 SHALL have port out_valid  out  1  result beat present.
REQ-011 SHALL have port out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have ports BU_a, BU_b  out  DW each: butterfly results.
REQ-013 SHALL have ports twiddle_BU_out, modulus_BU_out  out  DW each: w and q of the same beat.
REQ-014 SHALL have port busy  out  1  high while any pipeline stage or the output register holds a valid beat.

Function
REQ-015 SHALL compute CT beats as BU_a = (in1 + w*in2) mod q and BU_b = (in1 - w*in2) mod q; in_halve ignored.
REQ-016 SHALL compute GS beats as BU_a = (in1 + in2)*h mod q and BU_b = (in1 - in2)*w*h mod q; h = 2^-1 mod q if in_halve, else 1.
REQ-017 SHALL implement modular halving of x as x>>1 for even x and (x+q)>>1 for odd x, using a DW+1-bit intermediate.
REQ-018 SHALL compute the modular product from the full 2*DW-bit product, exactly reduced mod q, over MUL_LAT register stages.
REQ-019 SHALL return all results in [0, q-1] for operands < q and q < 2^(DW-1); out-of-range operands give undefined data but correct handshake.
REQ-020 SHALL give a latency of L = MUL_LAT+1 cycles from the accept edge to out_valid, in both modes, when no stall occurs.
REQ-021 SHALL order CT as multiply then add/sub, and GS as add/sub plus optional halving then multiply, delaying the GS sum by MUL_LAT stages to match.
REQ-022 SHALL carry twiddle and modulus with each beat so outputs pair with that beat's data.
REQ-023 SHALL sustain one beat per cycle in either mode.
REQ-024 SHALL stall the whole pipeline (all stages hold) while out_valid && !out_ready; in_ready SHALL then be 0.
REQ-025 SHALL hold a mode register, reset to 0 (CT), as the mode of all beats in flight.
REQ-026 SHALL hold in_ready at 0 while in_valid && in_mode != mode register && busy, so the pipeline drains.
REQ-027 SHALL load the mode register from in_mode on the accept edge once busy is 0 (mixed-mode pipeline never occurs).
REQ-028 SHALL, when an output beat is taken and a new input is accepted in the same cycle, advance both with no bubble.
REQ-029 SHALL not drop, duplicate or reorder beats under any in_valid/out_ready pattern.

Reset
REQ-030 SHALL, while rst_n = 0, clear all valid bits, the mode register, BU_a, BU_b, twiddle_BU_out and modulus_BU_out to 0, and drive out_valid = 0 and busy = 0.
REQ-031 SHALL discard all in-flight beats on reset assertion mid-operation; in_ready SHALL be 1 from the first edge after rst_n rises.

Verification (DW=32, MUL_LAT=2, q=7681)
REQ-032 SHALL cover CT: in1=100, in2=200, w=3 -> BU_a=700, BU_b=7181, out_valid 3 cycles after accept.
REQ-033 SHALL cover GS: in1=100, in2=200, w=3, halve=0 -> BU_a=300, BU_b=7381; with halve=1 -> BU_a=150, BU_b=7531.
REQ-034 SHALL cover backpressure: 8 back-to-back CT beats, out_ready low for cycles 4-6 -> in_ready low those cycles, all 8 results in order, none lost.
REQ-035 SHALL cover a mode switch: 3 CT beats then a GS beat -> in_ready low until busy=0, GS beat accepted the next cycle, correct GS result.
REQ-036 SHALL cover reset mid-stream: rst_n low with 3 beats in flight -> outputs 0 immediately, no stale beat emitted after release.
REQ-037 SHALL cover a random mixed-mode, random-stall run against a golden model over 10,000 beats with zero mismatches.
